// File: rtl/fetchcontrol_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetchcontrol_pkg                                                     |
// | Shared widths, PC increment and fetch sequencer state encodings.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetchcontrol_pkg;

  // Datapath widths inherited from the core bus definitions
  localparam int c_WORDSIZE = 64;
  localparam int c_INSTSIZE = 32;

  // Byte distance between consecutive instruction words
  localparam int c_PCINCR = 4;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetchcontrol_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetchcontrol_if                                                      |
// | Instruction-memory handshake, hazard/branch inputs and IF/ID feed.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fetchcontrol_if
  import fetchcontrol_pkg::*;
#(
  parameter int ADDRSIZE = c_WORDSIZE,
  parameter int INSTSIZE = c_INSTSIZE
);

  logic                imem_req;
  logic [ADDRSIZE-1:0] imem_addr;
  logic                imem_ack;
  logic [INSTSIZE-1:0] imem_data;
  logic                stall;
  logic                branch;
  logic [ADDRSIZE-1:0] target;
  logic [INSTSIZE-1:0] inst;
  logic [ADDRSIZE-1:0] inst_pc;
  logic                inst_valid;
  logic                flush;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid, flush,
    input  imem_ack, imem_data, stall, branch, target
  );

  // Memory / pipeline environment side
  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid, flush,
    output imem_ack, imem_data, stall, branch, target
  );

endinterface
`default_nettype wire

// File: rtl/fetchcontrol_instqueue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instqueue                                                            |
// | Two-entry FIFO of {inst, pc}; head is a register, clear beats push.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instqueue
  import fetchcontrol_pkg::*;
#(
  parameter int ADDRSIZE = c_WORDSIZE,
  parameter int INSTSIZE = c_INSTSIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic                clear,
  input  logic [INSTSIZE-1:0] push_inst,
  input  logic [ADDRSIZE-1:0] push_pc,
  output logic [1:0]          count,
  output logic [INSTSIZE-1:0] head_inst,
  output logic [ADDRSIZE-1:0] head_pc,
  output logic                head_valid
);

  logic [INSTSIZE-1:0] r_inst0, r_inst1;
  logic [ADDRSIZE-1:0] r_pc0, r_pc1;
  logic [1:0]          r_count;
  logic                w_pop, w_push;

  // Ignore pop of an empty queue and push into a full one without a pop
  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  // Entry 0 is always the head, so a pop shifts entry 1 down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst0 <= '0;
      r_inst1 <= '0;
      r_pc0   <= '0;
      r_pc1   <= '0;
      r_count <= 2'd0;
    end else if (clear) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_inst0 <= push_inst;
            r_pc0   <= push_pc;
          end else begin
            r_inst1 <= push_inst;
            r_pc1   <= push_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_inst0 <= r_inst1;
          r_pc0   <= r_pc1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_inst0 <= push_inst;
            r_pc0   <= push_pc;
          end else begin
            r_inst0 <= r_inst1;
            r_pc0   <= r_pc1;
            r_inst1 <= push_inst;
            r_pc1   <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = r_count;
  assign head_inst  = r_inst0;
  assign head_pc    = r_pc0;
  assign head_valid = (r_count != 2'd0);

endmodule
`default_nettype wire

// File: rtl/fetchcontrol.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetchcontrol                                                         |
// | LEGv8 fetch sequencer: owns the PC, issues one outstanding imem      |
// | request at a time, buffers words and redirects on taken branches.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetchcontrol
  import fetchcontrol_pkg::*;
#(
  parameter int                  ADDRSIZE = c_WORDSIZE,
  parameter int                  INSTSIZE = c_INSTSIZE,
  parameter logic [ADDRSIZE-1:0] RESETPC  = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  fetchcontrol_if.master bus
);

  localparam logic [ADDRSIZE-1:0] c_ALIGN_MASK = ~ADDRSIZE'(3);
  localparam logic [ADDRSIZE-1:0] c_RESETPC    = RESETPC & c_ALIGN_MASK;
  localparam logic [ADDRSIZE-1:0] c_PCSTEP     = ADDRSIZE'(c_PCINCR);

  fetch_state_t        r_state, w_state_nx;
  logic [ADDRSIZE-1:0] r_pc, w_pc_nx;
  logic [ADDRSIZE-1:0] r_addr, w_addr_nx;
  logic                r_req, w_req_nx;
  logic                r_flush;
  logic                w_acked, w_push, w_pop;
  logic [1:0]          w_qcount, w_count_nx;
  logic [INSTSIZE-1:0] w_head_inst;
  logic [ADDRSIZE-1:0] w_head_pc;
  logic                w_head_valid;

  // An ack only means something while a request is on the bus
  assign w_acked = r_req && bus.imem_ack;
  // Only data from a request still on the current path is kept
  assign w_push  = w_acked && (r_state == FETCH_RUN) && !bus.branch;
  assign w_pop   = w_head_valid && !bus.stall && !bus.branch;

  instqueue #(
    .ADDRSIZE (ADDRSIZE),
    .INSTSIZE (INSTSIZE)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push),
    .pop        (w_pop),
    .clear      (bus.branch),
    .push_inst  (bus.imem_data),
    .push_pc    (r_addr),
    .count      (w_qcount),
    .head_inst  (w_head_inst),
    .head_pc    (w_head_pc),
    .head_valid (w_head_valid)
  );

  // Sequencer state, PC, request and flush registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_IDLE;
      r_pc    <= c_RESETPC;
      r_addr  <= c_RESETPC;
      r_req   <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_addr  <= w_addr_nx;
      r_req   <= w_req_nx;
      r_flush <= bus.branch;
    end
  end

  // Next state, PC and request; issue looks at post-edge queue occupancy
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_addr_nx  = r_addr;
    w_req_nx   = r_req;
    w_count_nx = w_qcount;

    if (bus.branch)
      w_count_nx = 2'd0;
    else if (w_push && !w_pop)
      w_count_nx = w_qcount + 2'd1;
    else if (w_pop && !w_push)
      w_count_nx = w_qcount - 2'd1;

    case (r_state)
      FETCH_IDLE: w_state_nx = FETCH_RUN;
      FETCH_RUN: begin
        if (w_acked) begin
          w_req_nx = 1'b0;
          if (w_push)
            w_pc_nx = r_pc + c_PCSTEP;
        end
      end
      FETCH_DRAIN: begin
        if (w_acked) begin
          w_req_nx   = 1'b0;
          w_state_nx = FETCH_RUN;
        end
      end
      default: w_state_nx = FETCH_IDLE;
    endcase

    // A redirect wins over everything; a stranded request forces DRAIN
    if (bus.branch) begin
      w_pc_nx    = bus.target & c_ALIGN_MASK;
      w_state_nx = (r_req && !bus.imem_ack) ? FETCH_DRAIN : FETCH_RUN;
    end

    if ((r_state == FETCH_RUN) && !w_req_nx && (w_count_nx < 2'd2)) begin
      w_req_nx  = 1'b1;
      w_addr_nx = w_pc_nx;
    end
  end

  assign bus.imem_req   = r_req;
  assign bus.imem_addr  = r_addr;
  assign bus.flush      = r_flush;
  assign bus.inst       = w_head_inst;
  assign bus.inst_pc    = w_head_pc;
  assign bus.inst_valid = w_head_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetchcontrol.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetchcontrol                                                      |
// | Directed vector table, corner sequences and randomized traffic       |
// | against a queue-level fetch-stream model.                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetchcontrol;
  import fetchcontrol_pkg::*;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam logic [AW-1:0] RPC = 64'h100;
  localparam int NVEC = 30;
  localparam int NRND = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetchcontrol_if #(.ADDRSIZE(AW), .INSTSIZE(IW)) bus ();

  fetchcontrol #(.ADDRSIZE(AW), .INSTSIZE(IW), .RESETPC(RPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [63:0] addr;
    logic        vld;
    logic [63:0] ipc;
    logic        fl;
    logic        st;
    logic        ak;
    logic        br;
    logic [63:0] tg;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  vec_t vt[NVEC];
  ent_t mq[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Memory contents: a fixed function of the word address
  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic req, input logic [63:0] addr,
                              input logic vld, input logic [63:0] ipc,
                              input logic fl, input logic st, input logic ak,
                              input logic br, input logic [63:0] tg);
    vec_t v;
    v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc; v.fl = fl;
    v.st = st; v.ak = ak; v.br = br; v.tg = tg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic ak, input logic br, input logic [63:0] tg);
    bus.stall    = st;
    bus.imem_ack = ak;
    bus.branch   = br;
    bus.target   = tg;
    bus.imem_data = (ak && bus.imem_req) ? word(bus.imem_addr) : $urandom;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " req"},   64'(bus.imem_req), 64'd0);
    chk({tag, " addr"},  bus.imem_addr, RPC);
    chk({tag, " valid"}, 64'(bus.inst_valid), 64'd0);
    chk({tag, " inst"},  64'(bus.inst), 64'd0);
    chk({tag, " pc"},    bus.inst_pc, 64'd0);
    chk({tag, " flush"}, 64'(bus.flush), 64'd0);
  endtask

  logic        st, ak, br, prev_req, prev_ack, prev_br, stale;
  logic [63:0] tg, fp, prev_addr;
  int          starve, max_starve, consumed;

  initial begin
    // Memory acks one cycle after it first sees a request
    //         req addr                   vld ipc                    fl  st ak br target
    vt[0]  = mk(0, 64'h0,                 0, 64'h0,                 0,  0, 0, 0, 64'h0);
    vt[1]  = mk(1, 64'h100,               0, 64'h0,                 0,  0, 0, 0, 64'h0);
    vt[2]  = mk(1, 64'h100,               0, 64'h0,                 0,  0, 1, 0, 64'h0);
    vt[3]  = mk(1, 64'h104,               1, 64'h100,               0,  0, 0, 0, 64'h0);
    vt[4]  = mk(1, 64'h104,               0, 64'h0,                 0,  0, 1, 0, 64'h0);
    vt[5]  = mk(1, 64'h108,               1, 64'h104,               0,  0, 0, 0, 64'h0);
    vt[6]  = mk(1, 64'h108,               0, 64'h0,                 0,  0, 1, 0, 64'h0);
    vt[7]  = mk(1, 64'h10C,               1, 64'h108,               0,  1, 0, 0, 64'h0);
    vt[8]  = mk(1, 64'h10C,               1, 64'h108,               0,  1, 1, 0, 64'h0);
    vt[9]  = mk(0, 64'h0,                 1, 64'h108,               0,  1, 0, 0, 64'h0);
    vt[10] = mk(0, 64'h0,                 1, 64'h108,               0,  1, 1, 0, 64'h0);
    vt[11] = mk(0, 64'h0,                 1, 64'h108,               0,  1, 0, 0, 64'h0);
    vt[12] = mk(0, 64'h0,                 1, 64'h108,               0,  1, 0, 0, 64'h0);
    vt[13] = mk(0, 64'h0,                 1, 64'h108,               0,  0, 0, 0, 64'h0);
    vt[14] = mk(1, 64'h110,               1, 64'h10C,               0,  0, 0, 0, 64'h0);
    vt[15] = mk(1, 64'h110,               0, 64'h0,                 0,  0, 1, 0, 64'h0);
    vt[16] = mk(1, 64'h114,               1, 64'h110,               0,  0, 0, 0, 64'h0);
    vt[17] = mk(1, 64'h114,               0, 64'h0,                 0,  0, 1, 1, 64'h2003);
    vt[18] = mk(1, 64'h2000,              0, 64'h0,                 1,  0, 0, 0, 64'h0);
    vt[19] = mk(1, 64'h2000,              0, 64'h0,                 0,  0, 1, 0, 64'h0);
    vt[20] = mk(1, 64'h2004,              1, 64'h2000,              0,  0, 0, 0, 64'h0);
    vt[21] = mk(1, 64'h2004,              0, 64'h0,                 0,  0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    vt[22] = mk(1, 64'h2004,              0, 64'h0,                 1,  0, 0, 0, 64'h0);
    vt[23] = mk(1, 64'h2004,              0, 64'h0,                 0,  0, 1, 0, 64'h0);
    vt[24] = mk(0, 64'h0,                 0, 64'h0,                 0,  0, 0, 0, 64'h0);
    vt[25] = mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0,               0,  0, 0, 0, 64'h0);
    vt[26] = mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0,               0,  0, 1, 0, 64'h0);
    vt[27] = mk(1, 64'h0,                 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 64'h0);
    vt[28] = mk(1, 64'h0,                 0, 64'h0,                 0,  0, 1, 0, 64'h0);
    vt[29] = mk(1, 64'h4,                 1, 64'h0,                 0,  0, 0, 0, 64'h0);

    drive(0, 0, 0, 64'h0);
    step(); step(); step();
    chk_reset_vals("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step();
      chk($sformatf("vec%0d req", i), 64'(bus.imem_req), 64'(vt[i].req));
      if (vt[i].req)
        chk($sformatf("vec%0d addr", i), bus.imem_addr, vt[i].addr);
      chk($sformatf("vec%0d valid", i), 64'(bus.inst_valid), 64'(vt[i].vld));
      if (vt[i].vld) begin
        chk($sformatf("vec%0d inst_pc", i), bus.inst_pc, vt[i].ipc);
        chk($sformatf("vec%0d inst", i), 64'(bus.inst), 64'(word(vt[i].ipc)));
      end
      chk($sformatf("vec%0d flush", i), 64'(bus.flush), 64'(vt[i].fl));
      drive(vt[i].st, vt[i].ak, vt[i].br, vt[i].tg);
    end

    // Reset while a request to 0x4 is outstanding, then a late ack
    step();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async rst");
    drive(0, 1, 0, 64'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("stray ack req", 64'(bus.imem_req), 64'd0);
    chk("stray ack valid", 64'(bus.inst_valid), 64'd0);
    drive(0, 0, 0, 64'h0);
    step();
    chk("restart req", 64'(bus.imem_req), 64'd1);
    chk("restart addr", bus.imem_addr, RPC);
    chk("restart valid", 64'(bus.inst_valid), 64'd0);

    // Two redirects while the 0x100 request is still unacknowledged
    drive(0, 0, 1, 64'h3000);
    step();
    chk("drain1 flush", 64'(bus.flush), 64'd1);
    chk("drain1 addr held", bus.imem_addr, RPC);
    chk("drain1 req held", 64'(bus.imem_req), 64'd1);
    drive(0, 0, 1, 64'h4000);
    step();
    chk("drain2 flush", 64'(bus.flush), 64'd1);
    chk("drain2 addr held", bus.imem_addr, RPC);
    drive(0, 1, 0, 64'h0);
    step();
    chk("drain ack flush", 64'(bus.flush), 64'd0);
    chk("drain ack req", 64'(bus.imem_req), 64'd0);
    chk("drain ack valid", 64'(bus.inst_valid), 64'd0);
    drive(0, 0, 0, 64'h0);
    step();
    chk("post drain req", 64'(bus.imem_req), 64'd1);
    chk("post drain addr", bus.imem_addr, 64'h4000);
    chk("post drain valid", 64'(bus.inst_valid), 64'd0);

    // Randomized traffic against an in-order fetch-stream model
    rst_n = 1'b0;
    drive(0, 0, 0, 64'h0);
    step(); step();
    rst_n = 1'b1;
    mq.delete();
    fp = RPC; stale = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_br = 1'b0; prev_addr = 64'h0;
    starve = 0; max_starve = 0; consumed = 0;

    for (int c = 0; c < NRND; c++) begin
      step();
      chk("rnd flush", 64'(bus.flush), 64'(prev_br));
      chk("rnd valid", 64'(bus.inst_valid), 64'(mq.size() != 0));
      if (bus.inst_valid && mq.size() != 0) begin
        chk("rnd inst_pc", bus.inst_pc, mq[0].pc);
        chk("rnd inst", 64'(bus.inst), 64'(mq[0].ins));
      end
      if (bus.imem_req) begin
        chk("rnd align", 64'(bus.imem_addr[1:0]), 64'd0);
        if (prev_req && !prev_ack) begin
          chk("rnd hold", bus.imem_addr, prev_addr);
        end else begin
          chk("rnd issue addr", bus.imem_addr, fp);
          chk("rnd issue space", 64'(mq.size() < 2 && !stale), 64'd1);
        end
        starve = 0;
      end else if (mq.size() < 2) begin
        starve++;
        if (starve > max_starve) max_starve = starve;
      end else begin
        starve = 0;
      end

      st = ($urandom_range(0, 2) == 0);
      ak = bus.imem_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 15) == 0);
      tg = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0)
        tg = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      drive(st, ak, br, tg);

      if (!br && bus.inst_valid && !st) begin
        if (mq.size() != 0) void'(mq.pop_front());
        consumed++;
      end
      if (bus.imem_req && ak) begin
        if (!br && !stale) begin
          mq.push_back('{pc: fp, ins: word(fp)});
          fp = fp + 64'd4;
        end
        stale = 1'b0;
      end
      if (br) begin
        mq.delete();
        fp = tg & ~64'd3;
        if (bus.imem_req && !ak) stale = 1'b1;
      end

      prev_req  = bus.imem_req;
      prev_ack  = ak;
      prev_br   = br;
      prev_addr = bus.imem_addr;
    end

    chk("rnd starvation", 64'(max_starve <= 2), 64'd1);
    chk("rnd progress", 64'(consumed > 200), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
